// File: rtl/pipeline_control.sv
// pipeline_control: fetch/decode/execute sequencer for the CPU core.
//
// After reset it holds the datapath in reset for RESET_CYCLES edges, then runs
// a valid/ready fetch into a two-register pipeline (F/D, D/E). ARM data-processing
// and B instructions are decoded into the datapath control word. Condition codes
// are checked against the CPSR flags, and PC writes flush the pipeline.
//
// Ports:
//   clk, reset          clock (rising edge) and asynchronous active-high reset
//   stall               freeze pipeline registers and outputs, gate write enables
//   instr_valid/data    fetched instruction and its valid qualifier
//   cpsr_flags          {N,Z,C,V}
//   mem_read_en         fetch request
//   control_reset       datapath reset
//   address_reg_sel     00 ALU, 01 PC, 10 INC
//   reg_read_A_sel/B_sel, reg_read_B_en, imm_val, reg_write_sel   operand selection
//   reg_write_en, reg_pc_write_en, reg_cpsr_write_en              write enables
//   barrel_shift_val, barrel_op_sel, alu_op_sel                  shifter / ALU control
//   undef_pulse         one-cycle pulse when an undefined instruction executes
module pipeline_control #(
    parameter int unsigned REG_SEL_W      = 4,
    parameter int unsigned RESET_CYCLES   = 2,
    parameter int unsigned COND_EXEC      = 1,
    parameter int unsigned SUPPORT_BRANCH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 instr_valid,
    input  logic [31:0]          instr_data,
    input  logic [3:0]           cpsr_flags,
    output logic                 mem_read_en,
    output logic                 control_reset,
    output logic [1:0]           address_reg_sel,
    output logic [REG_SEL_W-1:0] reg_read_A_sel,
    output logic [REG_SEL_W-1:0] reg_read_B_sel,
    output logic                 reg_read_B_en,
    output logic [31:0]          imm_val,
    output logic [REG_SEL_W-1:0] reg_write_sel,
    output logic                 reg_write_en,
    output logic                 reg_pc_write_en,
    output logic                 reg_cpsr_write_en,
    output logic [7:0]           barrel_shift_val,
    output logic [2:0]           barrel_op_sel,
    output logic [3:0]           alu_op_sel,
    output logic                 undef_pulse
);

    typedef enum logic [0:0] {StRstSeq, StRun} state_t;

    // Decoded control word held in the D/E register.
    typedef struct packed {
        logic [3:0]  cond;
        logic [3:0]  a_sel;
        logic [3:0]  b_sel;
        logic        b_en;
        logic [31:0] imm;
        logic [3:0]  wr_sel;
        logic        wr_en;    // general register write (Rd != 15)
        logic        pc_en;    // PC write (Rd == 15 or branch)
        logic        s;
        logic [7:0]  shift;
        logic [2:0]  bop;
        logic [3:0]  alu;
        logic        undef;
    } ctrl_t;

    localparam logic [3:0] AluMov  = 4'b1101;
    localparam logic [3:0] AluAdd  = 4'b0100;
    localparam logic [3:0] CntLast = 4'(RESET_CYCLES - 1);

    localparam ctrl_t CtrlReset = '{
        cond: 4'h0, a_sel: 4'h0, b_sel: 4'h0, b_en: 1'b1, imm: 32'h0, wr_sel: 4'h0,
        wr_en: 1'b0, pc_en: 1'b0, s: 1'b0, shift: 8'h0, bop: 3'h0, alu: AluMov,
        undef: 1'b0
    };

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        fd_valid_q;
    logic [31:0] fd_instr_q;
    logic        de_valid_q;
    ctrl_t       de_q;
    ctrl_t       dec;
    logic        cond_pass;
    logic        exec_ok;
    logic        flush;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRstSeq;
            cnt_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRstSeq: begin
                if (cnt_q == CntLast) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + 4'h1;
                end
            end
            StRun: state_d = StRun;
            default: state_d = StRstSeq;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        control_reset   = (state_q == StRstSeq);
        mem_read_en     = (state_q == StRun) && !stall;
        address_reg_sel = flush ? 2'b00 : 2'b01;
    end

    // ---------------- Decode of the F/D instruction ----------------
    always_comb begin
        dec       = CtrlReset;
        dec.undef = 1'b1;
        dec.cond  = fd_instr_q[31:28];
        if (fd_instr_q[27:26] == 2'b00) begin
            if (!fd_instr_q[25] && fd_instr_q[4]) begin
                dec.undef = 1'b1;                       // register-specified shift
            end else if (fd_instr_q[24:23] == 2'b10 && !fd_instr_q[20]) begin
                dec.undef = 1'b1;                       // TST/TEQ/CMP/CMN without S
            end else begin
                dec.undef  = 1'b0;
                dec.a_sel  = fd_instr_q[19:16];
                dec.wr_sel = fd_instr_q[15:12];
                dec.alu    = fd_instr_q[24:21];
                dec.s      = fd_instr_q[20];
                // Compare/test ops only update flags.
                if (fd_instr_q[24:23] != 2'b10) begin
                    dec.wr_en = (fd_instr_q[15:12] != 4'hF);
                    dec.pc_en = (fd_instr_q[15:12] == 4'hF);
                end
                if (fd_instr_q[25]) begin
                    dec.b_en  = 1'b0;
                    dec.imm   = {24'h0, fd_instr_q[7:0]};
                    dec.bop   = 3'b011;
                    dec.shift = {3'b000, fd_instr_q[11:8], 1'b0};
                end else begin
                    dec.b_en  = 1'b1;
                    dec.b_sel = fd_instr_q[3:0];
                    dec.bop   = {1'b0, fd_instr_q[6:5]};
                    dec.shift = {3'b000, fd_instr_q[11:7]};
                    // Zero shift amount encodes LSR/ASR #32 and RRX.
                    if (fd_instr_q[11:7] == 5'd0) begin
                        unique case (fd_instr_q[6:5])
                            2'b01, 2'b10: dec.shift = 8'd32;
                            2'b11: begin
                                dec.bop   = 3'b100;
                                dec.shift = 8'd1;
                            end
                            default: dec.shift = 8'd0;
                        endcase
                    end
                end
            end
        end else if (SUPPORT_BRANCH != 0 && fd_instr_q[27:24] == 4'b1010) begin
            dec.undef = 1'b0;
            dec.a_sel = 4'hF;
            dec.b_en  = 1'b0;
            dec.imm   = {{6{fd_instr_q[23]}}, fd_instr_q[23:0], 2'b00};
            dec.alu   = AluAdd;
            dec.pc_en = 1'b1;
        end
    end

    // ---------------- Pipeline registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fd_valid_q <= 1'b0;
            fd_instr_q <= 32'h0;
            de_valid_q <= 1'b0;
            de_q       <= CtrlReset;
        end else if (state_q == StRun && !stall) begin
            if (flush) begin
                fd_valid_q <= 1'b0;
            end else if (instr_valid) begin
                fd_instr_q <= instr_data;
                fd_valid_q <= 1'b1;
            end else begin
                fd_valid_q <= 1'b0;
            end
            de_q       <= dec;
            de_valid_q <= fd_valid_q && !flush;
        end
    end

    // ---------------- Condition evaluation ----------------
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = cpsr_flags;
        cond_pass = 1'b0;
        if (COND_EXEC == 0) begin
            cond_pass = (de_q.cond != 4'hF);
        end else begin
            unique case (de_q.cond)
                4'h0: cond_pass = z;
                4'h1: cond_pass = !z;
                4'h2: cond_pass = c;
                4'h3: cond_pass = !c;
                4'h4: cond_pass = n;
                4'h5: cond_pass = !n;
                4'h6: cond_pass = v;
                4'h7: cond_pass = !v;
                4'h8: cond_pass = c && !z;
                4'h9: cond_pass = !c || z;
                4'hA: cond_pass = (n == v);
                4'hB: cond_pass = (n != v);
                4'hC: cond_pass = !z && (n == v);
                4'hD: cond_pass = z || (n != v);
                4'hE: cond_pass = 1'b1;
                default: cond_pass = 1'b0;
            endcase
        end
    end

    // ---------------- Execute outputs ----------------
    assign exec_ok           = de_valid_q && cond_pass && !stall;
    assign reg_write_en      = exec_ok && de_q.wr_en;
    assign reg_pc_write_en   = exec_ok && de_q.pc_en;
    assign reg_cpsr_write_en = exec_ok && de_q.s;
    assign undef_pulse       = de_valid_q && de_q.undef && !stall;
    // Stall already gates reg_pc_write_en, so a stalled flush waits.
    assign flush             = reg_pc_write_en;

    assign reg_read_A_sel   = REG_SEL_W'(de_q.a_sel);
    assign reg_read_B_sel   = REG_SEL_W'(de_q.b_sel);
    assign reg_write_sel    = REG_SEL_W'(de_q.wr_sel);
    assign reg_read_B_en    = de_q.b_en;
    assign imm_val          = de_q.imm;
    assign barrel_shift_val = de_q.shift;
    assign barrel_op_sel    = de_q.bop;
    assign alu_op_sel       = de_q.alu;

endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: directed vector table, hand-written multi-cycle
// sequences (reset length, branch flush, undef pulse, stall, async reset) and a
// randomized stream checked against a behavioural model.
module tb_pipeline_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_data = 32'h0;
    logic [3:0]  cpsr_flags = 4'h0;

    always #5 clk = ~clk;

    // Main instance (defaults)
    logic m_mre, m_cr, m_ben, m_wr, m_pc, m_cpsr, m_und;
    logic [1:0] m_addr;
    logic [3:0] m_a, m_b, m_w, m_alu;
    logic [31:0] m_imm;
    logic [7:0] m_sh;
    logic [2:0] m_bop;

    pipeline_control dut (
        .clk(clk), .reset(reset), .stall(stall), .instr_valid(instr_valid),
        .instr_data(instr_data), .cpsr_flags(cpsr_flags), .mem_read_en(m_mre),
        .control_reset(m_cr), .address_reg_sel(m_addr), .reg_read_A_sel(m_a),
        .reg_read_B_sel(m_b), .reg_read_B_en(m_ben), .imm_val(m_imm), .reg_write_sel(m_w),
        .reg_write_en(m_wr), .reg_pc_write_en(m_pc), .reg_cpsr_write_en(m_cpsr),
        .barrel_shift_val(m_sh), .barrel_op_sel(m_bop), .alu_op_sel(m_alu),
        .undef_pulse(m_und)
    );

    // RESET_CYCLES = 5 instance
    logic r_mre, r_cr, r_ben, r_wr, r_pc, r_cpsr, r_und;
    logic [1:0] r_addr;
    logic [3:0] r_a, r_b, r_w, r_alu;
    logic [31:0] r_imm;
    logic [7:0] r_sh;
    logic [2:0] r_bop;

    pipeline_control #(.RESET_CYCLES(5)) dut_r5 (
        .clk(clk), .reset(reset), .stall(stall), .instr_valid(instr_valid),
        .instr_data(instr_data), .cpsr_flags(cpsr_flags), .mem_read_en(r_mre),
        .control_reset(r_cr), .address_reg_sel(r_addr), .reg_read_A_sel(r_a),
        .reg_read_B_sel(r_b), .reg_read_B_en(r_ben), .imm_val(r_imm), .reg_write_sel(r_w),
        .reg_write_en(r_wr), .reg_pc_write_en(r_pc), .reg_cpsr_write_en(r_cpsr),
        .barrel_shift_val(r_sh), .barrel_op_sel(r_bop), .alu_op_sel(r_alu),
        .undef_pulse(r_und)
    );

    // COND_EXEC = 0 instance
    logic n_mre, n_cr, n_ben, n_wr, n_pc, n_cpsr, n_und;
    logic [1:0] n_addr;
    logic [3:0] n_a, n_b, n_w, n_alu;
    logic [31:0] n_imm;
    logic [7:0] n_sh;
    logic [2:0] n_bop;

    pipeline_control #(.COND_EXEC(0)) dut_nc (
        .clk(clk), .reset(reset), .stall(stall), .instr_valid(instr_valid),
        .instr_data(instr_data), .cpsr_flags(cpsr_flags), .mem_read_en(n_mre),
        .control_reset(n_cr), .address_reg_sel(n_addr), .reg_read_A_sel(n_a),
        .reg_read_B_sel(n_b), .reg_read_B_en(n_ben), .imm_val(n_imm), .reg_write_sel(n_w),
        .reg_write_en(n_wr), .reg_pc_write_en(n_pc), .reg_cpsr_write_en(n_cpsr),
        .barrel_shift_val(n_sh), .barrel_op_sel(n_bop), .alu_op_sel(n_alu),
        .undef_pulse(n_und)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = data processing, 1 = branch, 2 = undefined/NOP
    typedef struct {
        logic [31:0] instr;
        logic [3:0]  flags;
        int          kind;
        logic [3:0]  a, bsel, wsel;
        logic        ben;
        logic [31:0] imm;
        logic [7:0]  sh;
        logic [2:0]  bop;
        logic [3:0]  alu;
        logic        wr, pc, cpsr, und, nc_wr;
    } vec_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  a, bsel, wsel, alu;
        logic        ben, write, s;
        logic [31:0] imm;
        logic [7:0]  sh;
        logic [2:0]  bop;
    } ref_t;

    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ref_t ref_decode(input logic [31:0] i);
        ref_t r;
        int   amt, op, off;
        r   = '0;
        op  = int'(i[24:21]);
        amt = int'(i[11:7]);
        if (i[27:26] == 2'b00 && !(!i[25] && i[4]) && !(op >= 8 && op <= 11 && !i[20])) begin
            r.kind  = 2'd0;
            r.a     = i[19:16];
            r.wsel  = i[15:12];
            r.alu   = i[24:21];
            r.s     = i[20];
            r.write = !(op >= 8 && op <= 11);
            if (i[25]) begin
                r.ben = 1'b0;
                r.imm = 32'(i[7:0]);
                r.bop = 3'd3;
                r.sh  = 8'(2 * int'(i[11:8]));
            end else begin
                r.ben  = 1'b1;
                r.bsel = i[3:0];
                case (i[6:5])
                    2'd0: begin r.bop = 3'd0; r.sh = 8'(amt); end
                    2'd1: begin r.bop = 3'd1; r.sh = 8'(amt == 0 ? 32 : amt); end
                    2'd2: begin r.bop = 3'd2; r.sh = 8'(amt == 0 ? 32 : amt); end
                    default: begin
                        r.bop = (amt == 0) ? 3'd4 : 3'd3;
                        r.sh  = 8'(amt == 0 ? 1 : amt);
                    end
                endcase
            end
        end else if (i[27:25] == 3'b101 && !i[24]) begin
            r.kind = 2'd1;
            r.a    = 4'd15;
            r.ben  = 1'b0;
            r.alu  = 4'd4;
            off    = int'(i[23:0]);
            if (i[23]) off = off - (1 << 24);
            r.imm  = 32'(off * 4);
        end else begin
            r.kind = 2'd2;
        end
        return r;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [3:0] cond;
        logic [4:0] amt;
        cond = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom_range(0, 15));
        amt  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        case ($urandom_range(0, 4))
            0: return {cond, 3'b001, 4'($urandom), 1'($urandom), 8'($urandom), 12'($urandom)};
            1: return {cond, 3'b000, 4'($urandom), 1'($urandom), 8'($urandom), amt,
                       2'($urandom), 1'b0, 4'($urandom)};
            2: return {cond, 3'b000, 4'($urandom), 1'($urandom), 8'($urandom), 7'($urandom),
                       1'b1, 4'($urandom)};
            3: return {cond, 3'b101, 1'($urandom), 24'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[$];

    initial begin
        int   m_n, r5_n;
        logic fd_v, de_v;
        logic [31:0] fd_i, de_i;

        vecs.push_back('{32'hE2821005, 4'h0, 0, 4'd2, 4'd0, 4'd1, 1'b0, 32'd5, 8'd0, 3'd3, 4'h4,
                         1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'hE1B00023, 4'h0, 0, 4'd0, 4'd3, 4'd0, 1'b1, 32'd0, 8'd32, 3'd1, 4'hD,
                         1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{32'h02811001, 4'h0, 0, 4'd1, 4'd0, 4'd1, 1'b0, 32'd1, 8'd0, 3'd3, 4'h4,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'h02811001, 4'h4, 0, 4'd1, 4'd0, 4'd1, 1'b0, 32'd1, 8'd0, 3'd3, 4'h4,
                         1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'hE1A0F010, 4'h0, 2, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 8'd0, 3'd0, 4'h0,
                         1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'hE3510000, 4'h0, 0, 4'd1, 4'd0, 4'd0, 1'b0, 32'd0, 8'd0, 3'd3, 4'hA,
                         1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{32'hE1000000, 4'h0, 2, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 8'd0, 3'd0, 4'h0,
                         1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'hE281F004, 4'h0, 0, 4'd1, 4'd0, 4'd15, 1'b0, 32'd4, 8'd0, 3'd3, 4'h4,
                         1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'hE1A00060, 4'h0, 0, 4'd0, 4'd0, 4'd0, 1'b1, 32'd0, 8'd1, 3'd4, 4'hD,
                         1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'hE1A00040, 4'h0, 0, 4'd0, 4'd0, 4'd0, 1'b1, 32'd0, 8'd32, 3'd2, 4'hD,
                         1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'hE1A00001, 4'h0, 0, 4'd0, 4'd1, 4'd0, 1'b1, 32'd0, 8'd0, 3'd0, 4'hD,
                         1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'hE3A004FF, 4'h0, 0, 4'd0, 4'd0, 4'd0, 1'b0, 32'hFF, 8'd8, 3'd3, 4'hD,
                         1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'hEAFFFFFE, 4'h0, 1, 4'd15, 4'd0, 4'd0, 1'b0, 32'hFFFFFFF8, 8'd0, 3'd0,
                         4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'hEA000002, 4'h0, 1, 4'd15, 4'd0, 4'd0, 1'b0, 32'd8, 8'd0, 3'd0, 4'h4,
                         1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'hEB000000, 4'h0, 2, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 8'd0, 3'd0, 4'h0,
                         1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'hF2821005, 4'h0, 0, 4'd2, 4'd0, 4'd1, 1'b0, 32'd5, 8'd0, 3'd3, 4'h4,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'hA2821005, 4'h8, 0, 4'd2, 4'd0, 4'd1, 1'b0, 32'd5, 8'd0, 3'd3, 4'h4,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'hA2821005, 4'h9, 0, 4'd2, 4'd0, 4'd1, 1'b0, 32'd5, 8'd0, 3'd3, 4'h4,
                         1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'hE1A01221, 4'h0, 0, 4'd0, 4'd1, 4'd1, 1'b1, 32'd0, 8'd4, 3'd1, 4'hD,
                         1'b1, 1'b0, 1'b0, 1'b0, 1'b1});

        // ---------------- Reset values and reset sequence length ----------------
        #2 reset = 1'b1;
        #1;
        chk("rst control_reset", m_cr, 1);
        chk("rst address_reg_sel", m_addr, 2'b01);
        chk("rst alu_op_sel", m_alu, 4'hD);
        chk("rst reg_read_B_en", m_ben, 1);
        chk("rst mem_read_en", m_mre, 0);
        chk("rst write enables", {m_wr, m_pc, m_cpsr, m_und}, 0);
        chk("rst imm/sel", {m_imm, m_a, m_b, m_w, m_sh, m_bop}, 0);
        step();
        step();
        reset = 1'b0;
        m_n  = 0;
        r5_n = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (m_n == 0 && !m_cr) begin
                m_n = n;
                chk("mem_read_en after reset seq", m_mre, 1);
            end
            if (r5_n == 0 && !r_cr) r5_n = n;
            if (m_n != 0 && r5_n != 0) break;
        end
        chk("reset seq edges (2)", m_n, 2);
        chk("reset seq edges (5)", r5_n, 5);

        // ---------------- Directed vector table ----------------
        foreach (vecs[k]) begin
            cpsr_flags  = vecs[k].flags;
            instr_data  = vecs[k].instr;
            instr_valid = 1'b1;
            step();
            instr_valid = 1'b0;
            step();
            @(negedge clk);
            if (vecs[k].kind == 0) begin
                chk($sformatf("v%0d A_sel", k), m_a, vecs[k].a);
                chk($sformatf("v%0d write_sel", k), m_w, vecs[k].wsel);
                chk($sformatf("v%0d alu", k), m_alu, vecs[k].alu);
                chk($sformatf("v%0d B_en", k), m_ben, vecs[k].ben);
                if (vecs[k].ben) chk($sformatf("v%0d B_sel", k), m_b, vecs[k].bsel);
                else             chk($sformatf("v%0d imm", k), m_imm, vecs[k].imm);
                chk($sformatf("v%0d shift", k), m_sh, vecs[k].sh);
                chk($sformatf("v%0d barrel_op", k), m_bop, vecs[k].bop);
            end else if (vecs[k].kind == 1) begin
                chk($sformatf("v%0d br A_sel", k), m_a, vecs[k].a);
                chk($sformatf("v%0d br B_en", k), m_ben, vecs[k].ben);
                chk($sformatf("v%0d br imm", k), m_imm, vecs[k].imm);
                chk($sformatf("v%0d br alu", k), m_alu, vecs[k].alu);
            end
            chk($sformatf("v%0d reg_write_en", k), m_wr, vecs[k].wr);
            chk($sformatf("v%0d reg_pc_write_en", k), m_pc, vecs[k].pc);
            chk($sformatf("v%0d cpsr_write_en", k), m_cpsr, vecs[k].cpsr);
            chk($sformatf("v%0d undef_pulse", k), m_und, vecs[k].und);
            chk($sformatf("v%0d address_reg_sel", k), m_addr, vecs[k].pc ? 2'b00 : 2'b01);
            chk($sformatf("v%0d nocond reg_write_en", k), n_wr, vecs[k].nc_wr);
            step();
        end
        cpsr_flags = 4'h0;

        // ---------------- Branch followed by two ADDs ----------------
        instr_data  = 32'hEA000002;
        instr_valid = 1'b1;
        step();
        instr_data = 32'hE2821005;
        step();
        instr_data = 32'hE2823006;
        @(negedge clk);
        chk("br pc_write_en", m_pc, 1);
        chk("br A_sel", m_a, 15);
        chk("br imm", m_imm, 8);
        chk("br address_reg_sel", m_addr, 2'b00);
        step();
        instr_valid = 1'b0;
        @(negedge clk);
        chk("flush cyc1 enables", {m_wr, m_pc, m_cpsr}, 0);
        chk("flush cyc1 address_reg_sel", m_addr, 2'b01);
        step();
        @(negedge clk);
        chk("flush cyc2 enables", {m_wr, m_pc, m_cpsr}, 0);
        step();

        // ---------------- Undefined pulse is one cycle ----------------
        instr_data  = 32'hE1A0F010;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        @(negedge clk);
        chk("undef pulse high", m_und, 1);
        chk("undef no writes", {m_wr, m_pc, m_cpsr}, 0);
        step();
        @(negedge clk);
        chk("undef pulse low", m_und, 0);
        step();

        // ---------------- Stall for 3 cycles mid-stream ----------------
        instr_data  = 32'hE2821001;
        instr_valid = 1'b1;
        step();
        instr_data = 32'hE2823002;
        step();
        instr_data = 32'hE2825003;
        stall      = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk($sformatf("stall%0d write_sel", s), m_w, 1);
            chk($sformatf("stall%0d imm", s), m_imm, 1);
            chk($sformatf("stall%0d enables", s), {m_wr, m_pc, m_cpsr, m_mre}, 0);
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("resume I1 write", {m_wr, m_w}, {1'b1, 4'd1});
        chk("resume mem_read_en", m_mre, 1);
        step();
        instr_data = 32'hE2827004;
        @(negedge clk);
        chk("resume I2", {m_wr, m_w, m_imm}, {1'b1, 4'd3, 32'd2});
        step();
        instr_valid = 1'b0;
        @(negedge clk);
        chk("resume I3", {m_wr, m_w, m_imm}, {1'b1, 4'd5, 32'd3});
        step();
        @(negedge clk);
        chk("resume I4", {m_wr, m_w, m_imm}, {1'b1, 4'd7, 32'd4});
        step();
        step();

        // ---------------- Randomized stream vs. model ----------------
        fd_v = 1'b0;
        de_v = 1'b0;
        fd_i = 32'h0;
        de_i = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            ref_t r;
            logic go, e_wr, e_pc, e_cpsr, e_und;
            stall       = ($urandom_range(0, 4) == 0);
            instr_valid = ($urandom_range(0, 3) != 0);
            instr_data  = gen_instr();
            cpsr_flags  = 4'($urandom_range(0, 15));
            @(negedge clk);
            r      = ref_decode(de_i);
            go     = de_v && cond_ok(de_i[31:28], cpsr_flags) && !stall;
            e_wr   = go && r.kind == 2'd0 && r.write && r.wsel != 4'd15;
            e_pc   = go && ((r.kind == 2'd0 && r.write && r.wsel == 4'd15) || r.kind == 2'd1);
            e_cpsr = go && r.kind == 2'd0 && r.s;
            e_und  = de_v && r.kind == 2'd2 && !stall;
            chk("rnd enables", {m_mre, m_wr, m_pc, m_cpsr, m_und},
                {!stall, e_wr, e_pc, e_cpsr, e_und});
            chk("rnd address_reg_sel", m_addr, e_pc ? 2'b00 : 2'b01);
            if (de_v && r.kind != 2'd2) begin
                chk("rnd A/alu/B_en", {m_a, m_alu, m_ben}, {r.a, r.alu, r.ben});
                if (r.ben) chk("rnd B_sel", m_b, r.bsel);
                else       chk("rnd imm", m_imm, r.imm);
                if (r.kind == 2'd0) chk("rnd wsel/shift", {m_w, m_sh, m_bop}, {r.wsel, r.sh, r.bop});
            end
            // Advance the model across the coming edge.
            if (!stall) begin
                de_i = fd_i;
                de_v = fd_v && !e_pc;
                if (e_pc)             fd_v = 1'b0;
                else if (instr_valid) begin fd_i = instr_data; fd_v = 1'b1; end
                else                  fd_v = 1'b0;
            end
            step();
        end
        stall       = 1'b0;
        instr_valid = 1'b0;
        cpsr_flags  = 4'h0;
        step();
        step();

        // ---------------- Asynchronous reset mid-stream ----------------
        instr_data  = 32'hE2821005;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        @(negedge clk);
        chk("pre-reset write", m_wr, 1);
        #2 reset = 1'b1;
        #1;
        chk("async rst control_reset", m_cr, 1);
        chk("async rst outputs", {m_addr, m_alu, m_ben, m_imm, m_a, m_w},
            {2'b01, 4'hD, 1'b1, 32'd0, 4'd0, 4'd0});
        chk("async rst enables", {m_wr, m_pc, m_cpsr, m_und, m_mre}, 0);
        step();
        reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
Parametrised fetch/decode/execute sequencer for the CPU core, and the successor to the single-state fetch controller.
- Runs a configurable reset sequence, then a valid/ready fetch handshake into a 2-register pipeline (F/D, D/E).
- Decodes ARM data-processing and B instructions into the datapath control word.
- Evaluates condition codes against CPSR flags, handles stall, and flushes on PC writes.
- Sits between the memory/data-provider interface and the register file, barrel shifter and ALU.

Parameters:
REG_SEL_W, 4, width of register-select outputs (low 4 bits taken from the instruction, zero-extended).
RESET_CYCLES, 2, cycles control_reset stays high after reset release (1..15).
COND_EXEC, 1, 1 = evaluate cond field; 0 = treat every cond except 4'b1111 as AL.
SUPPORT_BRANCH, 1, 0 = B encodings decode as undefined.

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  asynchronous active-high reset.
stall  in  1  freeze all pipeline registers and outputs.
instr_valid  in  1  instr_data valid this cycle.
instr_data  in  32  fetched instruction.
cpsr_flags  in  4  {N,Z,C,V}, current CPSR.
mem_read_en  out  1  fetch request.
control_reset  out  1  datapath reset.
address_reg_sel  out  2  00 = ALU, 01 = PC, 10 = INC.
reg_read_A_sel  out  REG_SEL_W  Rn, or R15 for branches.
reg_read_B_sel  out  REG_SEL_W  Rm.
reg_read_B_en  out  1  0 = use imm_val instead of Rm.
imm_val  out  32  immediate operand.
reg_write_sel  out  REG_SEL_W  Rd.
reg_write_en  out  1  general register write.
reg_pc_write_en  out  1  PC write.
reg_cpsr_write_en  out  1  flags write.
barrel_shift_val  out  8  shift amount.
barrel_op_sel  out  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX.
alu_op_sel  out  4  ARM DP opcode encoding (1101 = MOV).
undef_pulse  out  1  one-cycle pulse when an undefined instruction reaches execute.

Behaviour:
- Reset (asynchronous, any state):
  - Go to RST_SEQ, clear fd_valid and de_valid.
  - control_reset=1, address_reg_sel=01, alu_op_sel=1101, reg_read_B_en=1.
  - All other outputs 0.
- FSM:
  - RST_SEQ counts RESET_CYCLES rising edges after reset deasserts, keeping control_reset=1.
  - Then go to RUN with control_reset=0. RUN is terminal until reset.
- Fetch:
  - In RUN, mem_read_en = !stall.
  - Edge with mem_read_en & instr_valid & !flush: fd_instr<=instr_data, fd_valid<=1.
  - Edge with mem_read_en & !instr_valid: fd_valid<=0.
- Decode:
  - Each non-stalled edge, the D/E control word <= decode(fd_instr) and de_valid<=fd_valid.
  - Execute outputs are the registered D/E word, so an instruction appears 2 edges after capture.
  - Throughput is 1 instruction per cycle.
- DP decode ([27:26]=00):
  - Fields: I=[25], op=[24:21], S=[20], Rn=[19:16], Rd=[15:12].
  - I=1: reg_read_B_en=0, imm_val={24'b0,[7:0]}, barrel ROR by 2*[11:8].
  - I=0 and [4]=0: B_sel=[3:0], type=[6:5], amount=[11:7].
  - Amount 0 special cases: LSR and ASR use 32; ROR becomes RRX with value 1; LSL stays 0.
  - I=0 and [4]=1 (register shift) is undefined.
  - op 1000..1011 with S=0 is undefined. With S=1: no register write.
- Branch ([27:25]=101, L=0):
  - A_sel=15, reg_read_B_en=0, imm_val=sign_extend([23:0])<<2, alu ADD, reg_pc_write_en.
  - L=1 is undefined.
- Undefined or other encodings decode as a NOP: all write enables 0; undef_pulse=1 in execute if de_valid.
- Write enables (combinational):
  - Enable = de_valid & decoded_enable & cond_pass & !stall.
  - cond_pass uses the ARM table for cond 0000..1110; 1111 always fails.
  - Rd=15 on a DP write: reg_pc_write_en instead of reg_write_en.
  - reg_cpsr_write_en = S & cond_pass. It applies even when Rd=15.
- Flush:
  - Triggered when reg_pc_write_en=1.
  - That cycle: address_reg_sel=00, and the fetch capture is discarded.
  - Next edge: fd_valid<=0, de_valid<=0.
  - Otherwise address_reg_sel=01.
- Stall: all registers hold, write enables 0, mem_read_en 0. Stall has priority over flush (flush waits).
- A failed condition never flushes.

Test Plan:
- Reset pulse, release -> control_reset=1 for exactly 2 edges, then mem_read_en=1; with RESET_CYCLES=5, 5 edges.
- Stream 0xE2821005 (ADD r1,r2,#5) -> 2 edges later: A_sel=2, write_sel=1, alu=0100, B_en=0, imm_val=5, ROR 0, reg_write_en=1.
- 0xE1B00023 (MOVS r0,r3,LSR #0) -> B_sel=3, barrel_op=001, shift=32, alu=1101, reg_write_en=1, cpsr_write_en=1.
- 0x02811001 (ADDEQ) with Z=0 -> all write enables 0; repeat with Z=1 -> reg_write_en=1; with COND_EXEC=0 and Z=0 -> reg_write_en=1.
- 0xEA000002 followed by two ADDs -> reg_pc_write_en=1, A_sel=15, imm_val=8, address_reg_sel=00; following 2 cycles have no write enables. 0xE1A0F010 (register shift) -> undef_pulse one cycle, no writes.
- Assert stall 3 cycles mid-stream -> outputs frozen, enables 0, resume without loss. Assert reset mid-stream -> outputs take reset values immediately, with no clock edge.
